// File: rtl/fe_control_array_bgpv.sv
// fe_control_array_bgpv
//   Front-end control for a group of NUM_PIX BGPV pixels. Each pixel has one
//   8-bit configuration register {gain_sel, t_dac[3:0], hit_or_en, cal_en,
//   hit_en}. Registers are written by address or by broadcast (Addr all-ones).
//   The block drives the per-pixel AFE controls and turns AFE or
//   digital-injection hits into synchronised single-cycle HitOut/HitOr pulses.
//
// Optional feature macro: FE_AUTO_MASK_EN
//   When defined, a per-pixel noise counter over a 2**WIN_W cycle window
//   clears a pixel's stored hit_en after NOISE_TH hits and sets MaskFlag.
//   When undefined, MaskFlag is tied low.
//
// Ports
//   Clk, ResetB     clock, asynchronous active-low reset
//   DefConf         force default configuration (DefCalEn supplies cal_en)
//   Wr, Addr, DataIn  configuration write (Addr all-ones = broadcast)
//   DataOut         registered effective config of Addr (0 if out of range)
//   S0, S1          global calibration switches
//   CalEdge         digital-injection strobe, EnDigHit selects it as hit source
//   AfeHit          asynchronous discriminator outputs
//   AfeS0/AfeS1/AfeThDac/AfeGainSel/AfePowerDown  per-pixel AFE controls
//   HitOut, HitOr   hit pulses, OR of enabled pulses one cycle later
//   MaskFlag        sticky auto-mask status
module fe_control_array_bgpv #(
  parameter int NUM_PIX     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = $clog2(NUM_PIX) + 1,
  parameter int WIN_W       = 10,
  parameter int CNT_W       = 4,
  parameter int NOISE_TH    = 12
) (
  input  logic                   Clk,
  input  logic                   ResetB,
  input  logic                   DefConf,
  input  logic                   DefCalEn,
  input  logic                   Wr,
  input  logic [AW-1:0]          Addr,
  input  logic [7:0]             DataIn,
  output logic [7:0]             DataOut,
  input  logic                   S0,
  input  logic                   S1,
  input  logic                   CalEdge,
  input  logic                   EnDigHit,
  input  logic [NUM_PIX-1:0]     AfeHit,
  output logic [NUM_PIX-1:0]     AfeS0,
  output logic [NUM_PIX-1:0]     AfeS1,
  output logic [4*NUM_PIX-1:0]   AfeThDac,
  output logic [NUM_PIX-1:0]     AfeGainSel,
  output logic [NUM_PIX-1:0]     AfePowerDown,
  output logic [NUM_PIX-1:0]     HitOut,
  output logic                   HitOr,
  output logic [NUM_PIX-1:0]     MaskFlag
);

  localparam logic [7:0] RESET_CFG = 8'hC5;

  logic [7:0]         cfg [NUM_PIX];
  logic [7:0]         eff [NUM_PIX];
  logic [NUM_PIX-1:0] hit_en, cal_en, hit_or_en;
  logic [NUM_PIX-1:0] wr_sel, mask_set, pre_edge;
  logic [7:0]         rd_data;

  // Effective configuration and the combinational AFE controls derived from it.
  always_comb begin
    AfeS0        = '0;
    AfeS1        = '0;
    AfeThDac     = '0;
    AfeGainSel   = '0;
    AfePowerDown = '0;
    hit_en       = '0;
    cal_en       = '0;
    hit_or_en    = '0;
    for (int unsigned p = 0; p < NUM_PIX; p++) begin
      eff[p]             = DefConf ? {1'b1, 4'b1000, 1'b1, DefCalEn, 1'b1} : cfg[p];
      hit_en[p]          = eff[p][0];
      cal_en[p]          = eff[p][1];
      hit_or_en[p]       = eff[p][2];
      AfeThDac[4*p +: 4] = eff[p][6:3];
      AfeGainSel[p]      = eff[p][7];
      AfePowerDown[p]    = ~eff[p][0];
      AfeS0[p]           = eff[p][1] ? S0 : 1'b1;
      AfeS1[p]           = eff[p][1] ? S1 : 1'b1;
    end
  end

  // Address decode: compare against each pixel index so out-of-range and
  // broadcast addresses never select a register for readback.
  always_comb begin
    rd_data = '0;
    wr_sel  = '0;
    for (int unsigned p = 0; p < NUM_PIX; p++) begin
      if (Addr == AW'(p)) rd_data = eff[p];
      wr_sel[p] = Wr & ((Addr == AW'(p)) | (&Addr));
    end
  end

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      for (int unsigned p = 0; p < NUM_PIX; p++) cfg[p] <= RESET_CFG;
    end else begin
      for (int unsigned p = 0; p < NUM_PIX; p++) begin
        if (wr_sel[p])        cfg[p]    <= DataIn;
        else if (mask_set[p]) cfg[p][0] <= 1'b0;
      end
    end
  end

  // Hit path. Both edge detectors run continuously; only the selection
  // between them follows EnDigHit, so a source switch cannot fabricate an edge.
  logic [NUM_PIX-1:0] sync [SYNC_STAGES];
  logic [NUM_PIX-1:0] afe_prev, afe_edge;
  logic               cal_q, dig_edge;

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      afe_prev <= '0;
      cal_q    <= 1'b0;
      HitOut   <= '0;
      HitOr    <= 1'b0;
      DataOut  <= '0;
    end else begin
      sync[0] <= AfeHit;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      afe_prev <= sync[SYNC_STAGES-1];
      cal_q    <= CalEdge;
      HitOut   <= pre_edge & hit_en;
      HitOr    <= |(HitOut & hit_or_en);
      DataOut  <= rd_data;
    end
  end

  always_comb begin
    afe_edge = sync[SYNC_STAGES-1] & ~afe_prev;
    dig_edge = CalEdge & ~cal_q;
    pre_edge = EnDigHit ? ({NUM_PIX{dig_edge}} & cal_en) : afe_edge;
  end

`ifdef FE_AUTO_MASK_EN
  logic [WIN_W-1:0]   win;
  logic               wrap;
  logic [CNT_W-1:0]   cnt     [NUM_PIX];
  logic [CNT_W-1:0]   cnt_nxt [NUM_PIX];
  logic [NUM_PIX-1:0] flag;

  always_comb begin
    wrap     = &win;
    mask_set = '0;
    for (int unsigned p = 0; p < NUM_PIX; p++) begin
      cnt_nxt[p] = cnt[p];
      if (wrap)                          cnt_nxt[p] = pre_edge[p] ? CNT_W'(1) : '0;
      else if (pre_edge[p] && cnt[p] != '1) cnt_nxt[p] = cnt[p] + 1'b1;
      mask_set[p] = pre_edge[p] && (cnt_nxt[p] == CNT_W'(NOISE_TH));
    end
  end

  // A write to a pixel restarts its count and clears its flag, overriding a
  // mask event in the same cycle.
  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      win  <= '0;
      flag <= '0;
      for (int unsigned p = 0; p < NUM_PIX; p++) cnt[p] <= '0;
    end else begin
      win <= win + 1'b1;
      for (int unsigned p = 0; p < NUM_PIX; p++) begin
        cnt[p]  <= wr_sel[p] ? '0 : cnt_nxt[p];
        flag[p] <= wr_sel[p] ? 1'b0 : (flag[p] | mask_set[p]);
      end
    end
  end

  assign MaskFlag = flag;
`else
  localparam int unused_mask_params = WIN_W + CNT_W + NOISE_TH;
  assign mask_set = '0;
  assign MaskFlag = '0;
`endif

endmodule

// File: tb/tb_fe_control_array_bgpv.sv
module tb_fe_control_array_bgpv;
  localparam int NUM_PIX = 8;
  localparam int SYNC    = 2;
  localparam int AW      = $clog2(NUM_PIX) + 1;
  localparam int WIN_W   = 10;
  localparam int CNT_W   = 4;
  localparam int NOISE_TH = 12;

  logic                 Clk = 1'b0, ResetB = 1'b0;
  logic                 DefConf = 1'b0, DefCalEn = 1'b0, Wr = 1'b0;
  logic [AW-1:0]        Addr = '0;
  logic [7:0]           DataIn = '0;
  logic                 S0 = 1'b0, S1 = 1'b0, CalEdge = 1'b0, EnDigHit = 1'b0;
  logic [NUM_PIX-1:0]   AfeHit = '0;
  logic [7:0]           DataOut;
  logic [NUM_PIX-1:0]   AfeS0, AfeS1, AfeGainSel, AfePowerDown, HitOut, MaskFlag;
  logic [4*NUM_PIX-1:0] AfeThDac;
  logic                 HitOr;

  always #5 Clk = ~Clk;

  fe_control_array_bgpv #(
    .NUM_PIX(NUM_PIX), .SYNC_STAGES(SYNC), .AW(AW),
    .WIN_W(WIN_W), .CNT_W(CNT_W), .NOISE_TH(NOISE_TH)
  ) dut (
    .Clk(Clk), .ResetB(ResetB), .DefConf(DefConf), .DefCalEn(DefCalEn),
    .Wr(Wr), .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
    .S0(S0), .S1(S1), .CalEdge(CalEdge), .EnDigHit(EnDigHit), .AfeHit(AfeHit),
    .AfeS0(AfeS0), .AfeS1(AfeS1), .AfeThDac(AfeThDac), .AfeGainSel(AfeGainSel),
    .AfePowerDown(AfePowerDown), .HitOut(HitOut), .HitOr(HitOr), .MaskFlag(MaskFlag)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]         m_cfg  [NUM_PIX];
  logic [NUM_PIX-1:0] a_hist [SYNC+1];   // a_hist[j]: AfeHit sampled j+1 edges ago
  logic               m_cal_prev;
  logic [7:0]         m_data;
  logic [NUM_PIX-1:0] m_hit, m_flag;
  logic               m_or;
  int                 m_cyc;
  int                 m_cnt [NUM_PIX];

  function automatic logic [7:0] eff_of(input int p);
    return DefConf ? {1'b1, 4'b1000, 1'b1, DefCalEn, 1'b1} : m_cfg[p];
  endfunction

  always @(posedge Clk or negedge ResetB) begin
    logic [NUM_PIX-1:0] pre, hit_n;
    logic [7:0]         e;
    logic               or_n;
    bit                 wrap;
    if (!ResetB) begin
      for (int p = 0; p < NUM_PIX; p++) begin m_cfg[p] = 8'hC5; m_cnt[p] = 0; end
      for (int i = 0; i <= SYNC; i++) a_hist[i] = '0;
      m_cal_prev = 1'b0; m_data = 8'h00; m_hit = '0; m_or = 1'b0; m_flag = '0; m_cyc = 0;
    end else begin
      m_data = (int'(Addr) < NUM_PIX) ? eff_of(int'(Addr)) : 8'h00;
      or_n = 1'b0;
      for (int p = 0; p < NUM_PIX; p++) begin
        e = eff_of(p);
        or_n = or_n | (m_hit[p] & e[2]);
        if (EnDigHit) pre[p] = CalEdge & ~m_cal_prev & e[1];
        else          pre[p] = a_hist[SYNC-1][p] & ~a_hist[SYNC][p];
        hit_n[p] = pre[p] & e[0];
      end
      m_or  = or_n;
      m_hit = hit_n;
      wrap = (m_cyc % (1 << WIN_W)) == (1 << WIN_W) - 1;
`ifdef FE_AUTO_MASK_EN
      for (int p = 0; p < NUM_PIX; p++) begin
        if (wrap) m_cnt[p] = pre[p] ? 1 : 0;
        else if (pre[p] && m_cnt[p] < (1 << CNT_W) - 1) m_cnt[p] = m_cnt[p] + 1;
        if (pre[p] && m_cnt[p] == NOISE_TH) begin m_cfg[p][0] = 1'b0; m_flag[p] = 1'b1; end
      end
`endif
      m_cyc++;
      if (Wr)
        for (int p = 0; p < NUM_PIX; p++)
          if (Addr == '1 || int'(Addr) == p) begin
            m_cfg[p] = DataIn; m_cnt[p] = 0; m_flag[p] = 1'b0;
          end
      for (int i = SYNC; i > 0; i--) a_hist[i] = a_hist[i-1];
      a_hist[0]  = AfeHit;
      m_cal_prev = CalEdge;
    end
  end

  // Per-cycle comparison, mid-cycle away from the active edge.
  always @(negedge Clk) begin
    logic [NUM_PIX-1:0]   s0e, s1e, gs, pd;
    logic [4*NUM_PIX-1:0] th;
    logic [7:0]           e;
    if (checking) begin
      for (int p = 0; p < NUM_PIX; p++) begin
        e = eff_of(p);
        s0e[p] = e[1] ? S0 : 1'b1;
        s1e[p] = e[1] ? S1 : 1'b1;
        gs[p]  = e[7];
        pd[p]  = ~e[0];
        th[4*p +: 4] = e[6:3];
      end
      check("DataOut", DataOut, m_data);
      check("HitOut", HitOut, m_hit);
      check("HitOr", HitOr, m_or);
      check("MaskFlag", MaskFlag, m_flag);
      check("AfeS0", AfeS0, s0e);
      check("AfeS1", AfeS1, s1e);
      check("AfeThDac", AfeThDac, th);
      check("AfeGainSel", AfeGainSel, gs);
      check("AfePowerDown", AfePowerDown, pd);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    Wr = 1'b1; Addr = a; DataIn = d;
    tick();
    Wr = 1'b0;
  endtask

  task automatic rd_expect(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
    Addr = a;
    tick();
    check(name, DataOut, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [NUM_PIX-1:0] hs [8];
    logic               ors [8];
    int                 n;

    // 1. reset state
    repeat (3) tick();
    checking = 1'b1;
    check("rst_HitOut", HitOut, 8'h00);
    check("rst_MaskFlag", MaskFlag, 8'h00);
    ResetB = 1'b1;
    for (int a = 0; a < NUM_PIX; a++) rd_expect(AW'(a), 8'hC5, "rst_read");
    check("rst_PowerDown", AfePowerDown, 8'h00);
    check("rst_ThDac", AfeThDac, 32'h8888_8888);
    rd_expect(AW'(NUM_PIX), 8'h00, "read_out_of_range");
    rd_expect('1, 8'h00, "read_broadcast");

    // 2. broadcast write, single write, default config
    wr('1, 8'h00);
    wr(AW'(3), 8'h07);
    for (int a = 0; a < NUM_PIX; a++) rd_expect(AW'(a), (a == 3) ? 8'h07 : 8'h00, "wr_read");
    check("wr_PowerDown", AfePowerDown, 8'hF7);
    S0 = 1'b0; S1 = 1'b1;
    tick();
    check("wr_AfeS0", AfeS0, 8'hF7);
    check("wr_AfeS1", AfeS1, 8'hFF);
    DefConf = 1'b1; DefCalEn = 1'b1;
    for (int a = 0; a < NUM_PIX; a++) rd_expect(AW'(a), 8'hC7, "defconf_read");
    check("defconf_PowerDown", AfePowerDown, 8'h00);
    DefConf = 1'b0; DefCalEn = 1'b0;
    rd_expect(AW'(3), 8'h07, "defconf_kept");

    // 3. AFE hit on pixel 3 held for 5 cycles
    for (int r = 0; r < 2; r++) begin
      AfeHit = 8'h08;
      for (int i = 0; i < 8; i++) begin
        tick();
        hs[i] = HitOut; ors[i] = HitOr;
        if (i == 4) AfeHit = 8'h00;
      end
      n = 0;
      for (int i = 0; i < 8; i++) if (hs[i] != 8'h00) n++;
      check("afe_pulse_count", n, 1);
      check("afe_pulse_at3", hs[2], 8'h08);
      if (r == 0) check("afe_or_at4", ors[3], 1'b1);
      else        check("afe_or_disabled", ors[3], 1'b0);
      wr(AW'(3), 8'h03);   // hit_or_en=0 for the second round
    end

    // 4. digital injection on pixels 1 and 5; AFE ignored
    wr(AW'(1), 8'h03);
    wr(AW'(5), 8'h03);
    wr(AW'(3), 8'h01);
    EnDigHit = 1'b1; AfeHit = 8'hFF; CalEdge = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); hs[i] = HitOut; end
    check("dig_pulse", hs[0], 8'h22);
    check("dig_single", hs[1] | hs[2] | hs[3], 8'h00);
    CalEdge = 1'b0;
    repeat (2) tick();
    EnDigHit = 1'b0;   // AfeHit already high: switching back must not pulse
    n = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (HitOut != 8'h00) n++; end
    check("switch_no_spurious", n, 0);
    AfeHit = 8'h00;
    repeat (4) tick();

`ifdef FE_AUTO_MASK_EN
    // 5. auto-mask
    wr(AW'(2), 8'h01);
    while ((m_cyc % (1 << WIN_W)) != 20) tick();
    n = 0;
    for (int i = 0; i < 13; i++) begin
      AfeHit[2] = 1'b1; tick(); n += int'(HitOut[2]);
      AfeHit[2] = 1'b0; tick(); n += int'(HitOut[2]);
    end
    repeat (4) begin tick(); n += int'(HitOut[2]); end
    check("am_pulses", n, 12);
    check("am_flag", MaskFlag, 8'h04);
    wr(AW'(2), 8'h01);
    check("am_flag_cleared", MaskFlag, 8'h00);
    while ((m_cyc % (1 << WIN_W)) != (1 << WIN_W) - 12) tick();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      AfeHit[2] = 1'b1; tick(); n += int'(HitOut[2]);
      AfeHit[2] = 1'b0; tick(); n += int'(HitOut[2]);
    end
    repeat (4) begin tick(); n += int'(HitOut[2]); end
    check("am_split_pulses", n, 12);
    check("am_split_noflag", MaskFlag, 8'h00);
`else
    check("nomask_flag", MaskFlag, 8'h00);
`endif

    // 6. asynchronous reset mid-pulse and mid-write
    AfeHit = 8'h02;
    repeat (3) tick();
    check("pre_reset_pulse", HitOut, 8'h02);
    Wr = 1'b1; Addr = '0; DataIn = 8'h55;
    #1 ResetB = 1'b0;
    #1;
    check("arst_DataOut", DataOut, 8'h00);
    check("arst_HitOut", HitOut, 8'h00);
    check("arst_HitOr", HitOr, 1'b0);
    check("arst_MaskFlag", MaskFlag, 8'h00);
    check("arst_ThDac", AfeThDac, 32'h8888_8888);
    check("arst_PowerDown", AfePowerDown, 8'h00);
    repeat (2) tick();
    Wr = 1'b0; AfeHit = 8'h00; ResetB = 1'b1;
    rd_expect('0, 8'hC5, "arst_read0");
    rd_expect(AW'(5), 8'hC5, "arst_read5");
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
